mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester scheduler in front of the single-ported byte memory. It shares that one memory port between the instruction-fetch stage and the load/store (MEM) stage. It serialises their requests with round-robin arbitration and models a configurable access latency. Each access drives exactly one memory-enable cycle and returns read data through a registered response.

## Interface
- LATENCY, 2, cycles spent in ACCESS per transaction (legal 1..15); memory enable is asserted only in the last one
- CLK  in  1  system clock, all state on rising edge
- RESET  in  1  asynchronous, active-high; clears all state immediately
- if_req_v  in  1  fetch request valid; fetch is always a read of size 3'd6 (64-bit)
- if_addr  in  64  fetch address
- if_flush  in  1  discard any in-flight or offered fetch
- if_req_ready  out  1  fetch request accepted this cycle
- if_resp_v  out  1  one-cycle pulse, fetch data valid
- if_resp_data  out  64  fetch data
- d_req_v  in  1  data request valid
- d_r_w  in  1  1 = store, 0 = load
- d_size  in  3  stores 0..3 (B/H/W/D), loads 0..6 (memory size encoding)
- d_addr  in  64  data address
- d_wdata  in  64  store data
- d_req_ready  out  1  data request accepted this cycle
- d_resp_v  out  1  one-cycle pulse, load data valid or store done
- d_resp_data  out  64  load data; 0 for stores
- mem_v  out  1  memory enable
- mem_r_w  out  1  memory direction
- mem_size  out  3  memory size code
- mem_addr  out  64  memory address
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  memory combinational read data

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE, arbitration:
  - Candidates are d_req_v and (if_req_v && !if_flush).
  - If only one candidate is present, it wins.
  - If both are present, the side not marked by last_grant wins.
  - The winner sees its *_req_ready = 1 (combinational, IDLE only). All request fields are latched, last_grant is updated, cnt is set to LATENCY-1, and the FSM goes to ACCESS.
- ACCESS:
  - mem_r_w, mem_size, mem_addr and mem_wdata are driven from the latched request for the whole state.
  - mem_v = 1 only when cnt == 0.
  - If cnt != 0, cnt decrements.
  - If cnt == 0, mem_rdata is captured into the response register (loads/fetches), the store commits at the same edge, and the FSM goes to RESP.
- RESP:
  - The owner's *_resp_v = 1 for exactly one cycle, then the FSM returns to IDLE.
  - No request is accepted in RESP.
- Flush:
  - if_flush high in any cycle while a fetch is in ACCESS or RESP sets a drop flag.
  - The access still completes (a read is harmless), but if_resp_v stays 0.
  - Flush never affects data transactions.
- last_grant resets to IF, so the data port wins the first simultaneous request.
- Response data registers hold their value until the next capture. d_resp_data is zeroed for stores.

## Timing
- Request accepted in IDLE cycle t:
  - ACCESS occupies cycles t+1..t+LATENCY.
  - mem_v is high in cycle t+LATENCY.
  - resp_v is high in cycle t+LATENCY+1.
  - The next accept is possible at t+LATENCY+2.
- Throughput: one transaction per LATENCY+2 cycles.
- Reset values:
  - Control outputs: mem_v, if_req_ready, d_req_ready, if_resp_v and d_resp_v are 0.
  - Memory-side outputs: mem_r_w, mem_size, mem_addr and mem_wdata are 0.
  - Response data and state: if_resp_data and d_resp_data are 0; cnt is 0, the drop flag is clear, last_grant is IF.
- RESET asserted mid-ACCESS:
  - mem_v drops asynchronously, so no write commits.
  - The transaction is lost with no response.
- Requesters must hold req fields stable until ready; fields are sampled only on the accept edge.
- mem_v is never high for more than one consecutive cycle, so each store commits exactly once.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - size constants SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3 (store), SZ_RD64=6;
  - owner constants OWN_IF / OWN_D.
- Sub-module rr_arb2 holds the two-input round-robin grant: inputs req[1:0], last_grant and an enable; outputs one-hot gnt[1:0].
- cnt is $clog2(LATENCY)+1 bits wide.

## Test plan
- Fetch alone, LATENCY=2, if_addr=0x40 with memory qword 0x1122334455667788 at 0x40 → if_req_ready in cycle 0, mem_v in cycle 2 only, if_resp_v in cycle 3 with data 0x1122334455667788.
- Simultaneous d_req_v (load, size 2, addr 0x8) and if_req_v right after reset → data is granted first and d_resp_v comes at cycle 3; fetch is granted at cycle 4 and if_resp_v comes at cycle 7.
- Store with size 3, addr 0x10, wdata 0xDEADBEEFCAFEF00D, then load with size 6 from 0x10 → store d_resp_v with data 0; the load returns 0xDEADBEEFCAFEF00D; mem_v is high for exactly one cycle per transaction.
- Fetch accepted, if_flush pulsed during ACCESS → if_resp_v never asserts; FSM returns to IDLE at the expected cycle; a following data request proceeds normally.
- RESET asserted during ACCESS of a store (before mem_v) → all outputs go to 0 immediately; memory content at that address is unchanged; FSM is in IDLE after release.
- Both requesters held valid continuously for 6 transactions → grants strictly alternate D, IF, D, IF, D, IF with a spacing of LATENCY+2 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // Store sizes are byte/half/word/double; fetches always use the 64-bit read code.
    localparam logic [2:0] SZ_B    = 3'd0;
    localparam logic [2:0] SZ_H    = 3'd1;
    localparam logic [2:0] SZ_W    = 3'd2;
    localparam logic [2:0] SZ_D    = 3'd3;
    localparam logic [2:0] SZ_RD64 = 3'd6;

    // Owner codes double as bit positions in the two-bit request/grant vectors.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef struct packed {
        logic        owner;
        logic        r_w;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a lone request wins, and on a tie the side that
// did not win last time is granted.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (last_grant == OWN_IF) ? (2'b01 << OWN_D) : (2'b01 << OWN_IF);
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported byte memory between instruction fetch and the MEM stage:
// round-robin accept in IDLE, LATENCY cycles of ACCESS with one enable cycle, one response cycle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        if_req_v,
    input  logic [63:0] if_addr,
    input  logic        if_flush,
    output logic        if_req_ready,
    output logic        if_resp_v,
    output logic [63:0] if_resp_data,
    input  logic        d_req_v,
    input  logic        d_r_w,
    input  logic [2:0]  d_size,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_req_ready,
    output logic        d_resp_v,
    output logic [63:0] d_resp_data,
    output logic        mem_v,
    output logic        mem_r_w,
    output logic [2:0]  mem_size,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam int               CNT_W    = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t           r_state;
    state_t           w_state_next;
    req_t             r_req;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_grant;
    logic             r_drop;
    logic [63:0]      r_if_rdata;
    logic [63:0]      r_d_rdata;
    logic [1:0]       w_req;
    logic [1:0]       w_gnt;
    logic             w_accept;
    logic             w_mem_fire;

    assign w_req[OWN_IF] = if_req_v && !if_flush;
    assign w_req[OWN_D]  = d_req_v;

    // Gating with RESET keeps the ready outputs low while reset is held.
    rr_arb2 u_rr_arb2 (
        .req        (w_req),
        .last_grant (r_last_grant),
        .en         ((r_state == IDLE) && !RESET),
        .gnt        (w_gnt)
    );

    assign if_req_ready = w_gnt[OWN_IF];
    assign d_req_ready  = w_gnt[OWN_D];
    assign w_accept     = |w_gnt;
    assign w_mem_fire   = (r_state == ACCESS) && (r_cnt == '0);
    assign if_resp_data = r_if_rdata;
    assign d_resp_data  = r_d_rdata;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        mem_v        = 1'b0;
        mem_r_w      = 1'b0;
        mem_size     = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if_resp_v    = 1'b0;
        d_resp_v     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = ACCESS;
            end
            ACCESS: begin
                mem_r_w   = r_req.r_w;
                mem_size  = r_req.size;
                mem_addr  = r_req.addr;
                mem_wdata = r_req.wdata;
                if (r_cnt == '0) begin
                    mem_v        = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = IDLE;
                if (r_req.owner == OWN_D) d_resp_v = 1'b1;
                else                      if_resp_v = !r_drop && !if_flush;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_req        <= '0;
            r_cnt        <= '0;
            r_last_grant <= OWN_IF;
            r_drop       <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_gnt[OWN_D] ? OWN_D : OWN_IF;
                r_cnt        <= CNT_LOAD;
                r_drop       <= 1'b0;
                if (w_gnt[OWN_D]) begin
                    r_req.owner <= OWN_D;
                    r_req.r_w   <= d_r_w;
                    r_req.size  <= d_size;
                    r_req.addr  <= d_addr;
                    r_req.wdata <= d_wdata;
                end else begin
                    r_req.owner <= OWN_IF;
                    r_req.r_w   <= 1'b0;
                    r_req.size  <= SZ_RD64;
                    r_req.addr  <= if_addr;
                    r_req.wdata <= '0;
                end
            end
            if ((r_state == ACCESS) && (r_cnt != '0)) r_cnt <= r_cnt - CNT_W'(1);
            if (w_mem_fire) begin
                if (r_req.owner == OWN_D) r_d_rdata  <= r_req.r_w ? '0 : mem_rdata;
                else                      r_if_rdata <= mem_rdata;
            end
            // A flushed fetch still finishes its read; only its response is suppressed.
            if ((r_state == ACCESS || r_state == RESP) && (r_req.owner == OWN_IF) && if_flush)
                r_drop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a little-endian byte memory model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        if_req_v, if_flush, if_req_ready, if_resp_v;
    logic [63:0] if_addr, if_resp_data;
    logic        d_req_v, d_r_w, d_req_ready, d_resp_v;
    logic [2:0]  d_size;
    logic [63:0] d_addr, d_wdata, d_resp_data;
    logic        mem_v, mem_r_w;
    logic [2:0]  mem_size;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0]  mem [0:255];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [63:0] pre_data;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.LATENCY(2)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .if_req_v     (if_req_v),
        .if_addr      (if_addr),
        .if_flush     (if_flush),
        .if_req_ready (if_req_ready),
        .if_resp_v    (if_resp_v),
        .if_resp_data (if_resp_data),
        .d_req_v      (d_req_v),
        .d_r_w        (d_r_w),
        .d_size       (d_size),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_req_ready  (d_req_ready),
        .d_resp_v     (d_resp_v),
        .d_resp_data  (d_resp_data),
        .mem_v        (mem_v),
        .mem_r_w      (mem_r_w),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = mem[mem_addr[7:0] + 8'(i)];
    end

    always @(posedge CLK) begin
        if (pre_we)
            for (int i = 0; i < 8; i++) mem[pre_addr + 8'(i)] <= pre_data[8*i +: 8];
        if (mem_v && mem_r_w)
            for (int i = 0; i < 8; i++)
                if (i < (1 << mem_size)) mem[mem_addr[7:0] + 8'(i)] <= mem_wdata[8*i +: 8];
    end

    task automatic preload(input logic [7:0] a, input logic [63:0] d);
        @(negedge CLK);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge CLK);
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        if_req_v = 1'b1; if_addr = 64'h40; d_req_v = 1'b1; d_addr = 64'h8;
        #1;
        checks++; if ({mem_v, if_req_ready, d_req_ready, if_resp_v, d_resp_v} !== 5'b0) begin
            errors++; $display("FAIL reset ctrl: got %b want 00000", {mem_v, if_req_ready, d_req_ready, if_resp_v, d_resp_v}); end
        checks++; if ({mem_r_w, mem_size, mem_addr, mem_wdata} !== '0) begin
            errors++; $display("FAIL reset mem side: got r_w=%b size=%0d addr=%h wdata=%h want all 0", mem_r_w, mem_size, mem_addr, mem_wdata); end
        checks++; if ({if_resp_data, d_resp_data} !== '0) begin
            errors++; $display("FAIL reset resp data: got if=%h d=%h want 0", if_resp_data, d_resp_data); end
        if_req_v = 1'b0; d_req_v = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_fetch_alone();
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if_req_v = (c == 0); if_addr = 64'h40;
            #1;
            checks++; if (if_req_ready !== (c == 0)) begin
                errors++; $display("FAIL fetch ready cyc %0d: got %b want %b", c, if_req_ready, c == 0); end
            checks++; if (mem_v !== (c == 2)) begin
                errors++; $display("FAIL fetch mem_v cyc %0d: got %b want %b", c, mem_v, c == 2); end
            checks++; if (if_resp_v !== (c == 3)) begin
                errors++; $display("FAIL fetch resp_v cyc %0d: got %b want %b", c, if_resp_v, c == 3); end
            if (c == 2) begin
                checks++; if ({mem_r_w, mem_size, mem_addr} !== {1'b0, SZ_RD64, 64'h40}) begin
                    errors++; $display("FAIL fetch mem fields: got r_w=%b size=%0d addr=%h want 0/6/40", mem_r_w, mem_size, mem_addr); end
            end
            if (c == 3) begin
                checks++; if (if_resp_data !== 64'h1122334455667788) begin
                    errors++; $display("FAIL fetch data: got %h want 1122334455667788", if_resp_data); end
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge CLK);
            d_req_v = (c == 0); d_r_w = 1'b0; d_size = SZ_W; d_addr = 64'h8;
            if_req_v = (c <= 4); if_addr = 64'h40;
            #1;
            checks++; if (d_req_ready !== (c == 0)) begin
                errors++; $display("FAIL simul d_ready cyc %0d: got %b want %b", c, d_req_ready, c == 0); end
            checks++; if (if_req_ready !== (c == 4)) begin
                errors++; $display("FAIL simul if_ready cyc %0d: got %b want %b", c, if_req_ready, c == 4); end
            checks++; if (mem_v !== (c == 2 || c == 6)) begin
                errors++; $display("FAIL simul mem_v cyc %0d: got %b want %b", c, mem_v, c == 2 || c == 6); end
            checks++; if (d_resp_v !== (c == 3)) begin
                errors++; $display("FAIL simul d_resp_v cyc %0d: got %b want %b", c, d_resp_v, c == 3); end
            checks++; if (if_resp_v !== (c == 7)) begin
                errors++; $display("FAIL simul if_resp_v cyc %0d: got %b want %b", c, if_resp_v, c == 7); end
            if (c == 2) begin
                checks++; if ({mem_size, mem_addr} !== {SZ_W, 64'h8}) begin
                    errors++; $display("FAIL simul load fields: got size=%0d addr=%h want 2/8", mem_size, mem_addr); end
            end
            if (c == 3) begin
                checks++; if (d_resp_data !== 64'h0807060504030201) begin
                    errors++; $display("FAIL simul load data: got %h want 0807060504030201", d_resp_data); end
            end
            if (c == 7) begin
                checks++; if (if_resp_data !== 64'h1122334455667788) begin
                    errors++; $display("FAIL simul fetch data: got %h want 1122334455667788", if_resp_data); end
            end
        end
    endtask

    task automatic test_store_load();
        int pulses = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge CLK);
            d_req_v = (c == 0 || c == 4); d_r_w = (c == 0);
            d_size = (c == 0) ? SZ_D : SZ_RD64; d_addr = 64'h10; d_wdata = 64'hDEADBEEFCAFEF00D;
            #1;
            if (mem_v) pulses++;
            checks++; if (d_req_ready !== (c == 0 || c == 4)) begin
                errors++; $display("FAIL stld d_ready cyc %0d: got %b want %b", c, d_req_ready, c == 0 || c == 4); end
            checks++; if (mem_v !== (c == 2 || c == 6)) begin
                errors++; $display("FAIL stld mem_v cyc %0d: got %b want %b", c, mem_v, c == 2 || c == 6); end
            checks++; if (d_resp_v !== (c == 3 || c == 7)) begin
                errors++; $display("FAIL stld d_resp_v cyc %0d: got %b want %b", c, d_resp_v, c == 3 || c == 7); end
            if (c == 2) begin
                checks++; if ({mem_r_w, mem_size, mem_wdata} !== {1'b1, SZ_D, 64'hDEADBEEFCAFEF00D}) begin
                    errors++; $display("FAIL stld store fields: got r_w=%b size=%0d wdata=%h", mem_r_w, mem_size, mem_wdata); end
            end
            if (c == 3) begin
                checks++; if (d_resp_data !== 64'h0) begin
                    errors++; $display("FAIL stld store resp data: got %h want 0", d_resp_data); end
            end
            if (c == 7) begin
                checks++; if (d_resp_data !== 64'hDEADBEEFCAFEF00D) begin
                    errors++; $display("FAIL stld load data: got %h want deadbeefcafef00d", d_resp_data); end
            end
        end
        checks++; if (pulses !== 2) begin
            errors++; $display("FAIL stld mem_v pulses: got %0d want 2", pulses); end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 13; c++) begin
            @(negedge CLK);
            if_req_v = (c == 0 || c == 8); if_addr = 64'h40; if_flush = (c == 1);
            d_req_v = (c == 4); d_r_w = 1'b0; d_size = SZ_D; d_addr = 64'h8;
            #1;
            checks++; if (if_req_ready !== (c == 0 || c == 8)) begin
                errors++; $display("FAIL flush if_ready cyc %0d: got %b want %b", c, if_req_ready, c == 0 || c == 8); end
            checks++; if (d_req_ready !== (c == 4)) begin
                errors++; $display("FAIL flush d_ready cyc %0d: got %b want %b", c, d_req_ready, c == 4); end
            checks++; if (mem_v !== (c == 2 || c == 6 || c == 10)) begin
                errors++; $display("FAIL flush mem_v cyc %0d: got %b want %b", c, mem_v, c == 2 || c == 6 || c == 10); end
            checks++; if (if_resp_v !== (c == 11)) begin
                errors++; $display("FAIL flush if_resp_v cyc %0d: got %b want %b", c, if_resp_v, c == 11); end
            checks++; if (d_resp_v !== (c == 7)) begin
                errors++; $display("FAIL flush d_resp_v cyc %0d: got %b want %b", c, d_resp_v, c == 7); end
            if (c == 7) begin
                checks++; if (d_resp_data !== 64'h0807060504030201) begin
                    errors++; $display("FAIL flush load data: got %h want 0807060504030201", d_resp_data); end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge CLK);
        d_req_v = 1'b1; d_r_w = 1'b1; d_size = SZ_D; d_addr = 64'h20; d_wdata = 64'h0123456789ABCDEF;
        #1;
        checks++; if (d_req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid accept: got %b want 1", d_req_ready); end
        @(negedge CLK);
        d_req_v = 1'b0;
        #1;
        checks++; if ({mem_r_w, mem_addr} !== {1'b1, 64'h20}) begin
            errors++; $display("FAIL rst_mid access fields: got r_w=%b addr=%h want 1/20", mem_r_w, mem_addr); end
        RESET = 1'b1;
        #1;
        checks++; if ({mem_v, if_req_ready, d_req_ready, if_resp_v, d_resp_v, mem_r_w, mem_size} !== 9'b0) begin
            errors++; $display("FAIL rst_mid ctrl: got %b want 0", {mem_v, if_req_ready, d_req_ready, if_resp_v, d_resp_v, mem_r_w, mem_size}); end
        checks++; if ({mem_addr, mem_wdata, if_resp_data, d_resp_data} !== '0) begin
            errors++; $display("FAIL rst_mid data: got addr=%h wdata=%h if=%h d=%h want 0", mem_addr, mem_wdata, if_resp_data, d_resp_data); end
        @(negedge CLK);
        RESET = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            d_req_v = (c == 0); d_r_w = 1'b0; d_size = SZ_RD64; d_addr = 64'h20;
            #1;
            checks++; if (d_req_ready !== (c == 0)) begin
                errors++; $display("FAIL rst_mid d_ready cyc %0d: got %b want %b", c, d_req_ready, c == 0); end
            checks++; if (d_resp_v !== (c == 3)) begin
                errors++; $display("FAIL rst_mid d_resp_v cyc %0d: got %b want %b", c, d_resp_v, c == 3); end
            if (c == 3) begin
                checks++; if (d_resp_data !== 64'h5555555555555555) begin
                    errors++; $display("FAIL rst_mid mem unchanged: got %h want 5555555555555555", d_resp_data); end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 24; c++) begin
            @(negedge CLK);
            d_req_v = (c <= 21); d_r_w = 1'b0; d_size = SZ_D; d_addr = 64'h8;
            if_req_v = (c <= 21); if_addr = 64'h40;
            #1;
            checks++; if (d_req_ready !== (c == 0 || c == 8 || c == 16)) begin
                errors++; $display("FAIL b2b d_ready cyc %0d: got %b want %b", c, d_req_ready, c == 0 || c == 8 || c == 16); end
            checks++; if (if_req_ready !== (c == 4 || c == 12 || c == 20)) begin
                errors++; $display("FAIL b2b if_ready cyc %0d: got %b want %b", c, if_req_ready, c == 4 || c == 12 || c == 20); end
            checks++; if (d_resp_v !== (c == 3 || c == 11 || c == 19)) begin
                errors++; $display("FAIL b2b d_resp_v cyc %0d: got %b want %b", c, d_resp_v, c == 3 || c == 11 || c == 19); end
            checks++; if (if_resp_v !== (c == 7 || c == 15 || c == 23)) begin
                errors++; $display("FAIL b2b if_resp_v cyc %0d: got %b want %b", c, if_resp_v, c == 7 || c == 15 || c == 23); end
            if (c == 23) begin
                checks++; if ({if_resp_data, d_resp_data} !== {64'h1122334455667788, 64'h0807060504030201}) begin
                    errors++; $display("FAIL b2b data: got if=%h d=%h", if_resp_data, d_resp_data); end
            end
        end
        if_req_v = 1'b0; d_req_v = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        if_req_v = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req_v = 1'b0; d_r_w = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
        preload(8'h40, 64'h1122334455667788);
        preload(8'h08, 64'h0807060504030201);
        preload(8'h10, 64'hAAAAAAAAAAAAAAAA);
        preload(8'h20, 64'h5555555555555555);
        test_reset();
        test_fetch_alone();
        test_simultaneous();
        test_store_load();
        test_flush();
        test_reset_mid_access();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
